// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory, its boot loader and the
// fetch unit. Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CSUM
// state used by the loader's trailing checksum byte.
package imem_pkg;

  localparam int INST_W = 19;
  localparam int ADDR_W = 8;

  // Bits of the third instruction byte that lie above INST_W and must be 0.
  localparam logic [7:0] RSVD_MASK = 8'hF8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_B0,
    ST_B1,
    ST_B2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERR
  } ld_state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles one instruction from three little-endian bytes and flags an
// incoming top byte whose reserved bits are set.
module imem_byte_packer
  import imem_pkg::*;
#(
  parameter int INST_W = imem_pkg::INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [INST_W-1:0] word,
  output logic              rsvd_nz
);

  logic [INST_W-1:0] word_q, word_d;
  logic [1:0]        idx_q, idx_d;

  // Next word/slot: clear on a new load, otherwise drop the byte into its slot.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clr) begin
      word_d = '0;
      idx_d  = 2'd0;
    end else if (shift_en) begin
      case (idx_q)
        2'd0: begin
          word_d[7:0] = byte_in;
          idx_d       = 2'd1;
        end
        2'd1: begin
          word_d[15:8] = byte_in;
          idx_d        = 2'd2;
        end
        default: begin
          word_d[INST_W-1:16] = byte_in[INST_W-17:0];
          idx_d               = 2'd0;
        end
      endcase
    end
  end

  // Word and slot-index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word    = word_q;
  assign rsvd_nz = |(byte_in & RSVD_MASK);

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: length byte, then 3 bytes per instruction, one memory
// write per word at sequential addresses from 0. Optional feature macro:
// IMEM_LOADER_CHECKSUM_EN appends an XOR checksum byte after the last word.
module imem_loader
  import imem_pkg::*;
#(
  parameter int INST_W = imem_pkg::INST_W,
  parameter int ADDR_W = imem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [INST_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d, len_q, len_d, count_inc;
  logic              wr_en_q, wr_en_d;
  logic              in_load, hs, shift_en, pk_clr, rsvd_nz, start_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // Decode of the states that take bytes from the stream.
  always_comb begin
    in_load = 1'b0;
    case (state_q)
      ST_LEN, ST_B0, ST_B1, ST_B2: in_load = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM:                     in_load = 1'b1;
`endif
      default:                     in_load = 1'b0;
    endcase
  end

  // The write cycle itself takes no byte, giving 3 bytes per 4 cycles.
  assign byte_ready = in_load & ~wr_en_q;
  assign hs         = byte_valid & byte_ready;
  assign start_ok   = start & ~in_load;
  assign shift_en   = hs & ((state_q == ST_B0) | (state_q == ST_B1) | (state_q == ST_B2));
  assign pk_clr     = start_ok;
  assign count_inc  = word_count_q + (ADDR_W+1)'(1);

  imem_byte_packer #(.INST_W(INST_W)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .shift_en (shift_en),
    .byte_in  (byte_in),
    .word     (wr_data),
    .rsvd_nz  (rsvd_nz)
  );

  // Next-state, counters and write strobe; start outranks a same-cycle byte.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_addr_d    = wr_addr_q;
    word_count_d = word_count_q;
    len_d        = len_q;
    wr_en_d      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
    if (shift_en) csum_d = csum_q ^ byte_in;
`endif
    if (start_ok) begin
      state_d      = ST_LEN;
      addr_d       = '0;
      wr_addr_d    = '0;
      word_count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d       = 8'd0;
`endif
    end else if (hs) begin
      case (state_q)
        ST_LEN: begin
          // A length of 0 stands for a full 2^ADDR_W-word image.
          len_d   = (byte_in == 8'd0) ? (ADDR_W+1)'(1 << ADDR_W) : (ADDR_W+1)'(byte_in);
          state_d = ST_B0;
        end
        ST_B0: state_d = ST_B1;
        ST_B1: state_d = ST_B2;
        ST_B2: begin
          if (rsvd_nz) begin
            state_d = ST_ERR;
          end else begin
            wr_en_d      = 1'b1;
            wr_addr_d    = addr_q;
            addr_d       = addr_q + ADDR_W'(1);
            word_count_d = count_inc;
            if (count_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_DONE;
`endif
            end else begin
              state_d = ST_B0;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: state_d = (byte_in == csum_q) ? ST_DONE : ST_ERR;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      word_count_q <= '0;
      len_q        <= '0;
      wr_en_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      word_count_q <= word_count_d;
      len_q        <= len_d;
      wr_en_q      <= wr_en_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign busy       = in_load;
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued as bytes
// are driven and compared by a write monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, wr_en, busy, done, err;
  logic [7:0]  wr_addr;
  logic [18:0] wr_data;
  logic [8:0]  word_count;

  int checks = 0;
  int errors = 0;
  int n_writes = 0;

  typedef struct packed {
    logic [7:0]  a;
    logic [18:0] d;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] exp_addr;
  logic [7:0] exp_csum;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", wr_addr, wr_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d) begin
          errors++;
          $display("FAIL write_content got addr=%0d data=%h want addr=%0d data=%h",
                   wr_addr, wr_data, e.a, e.d);
        end
      end
      checks++;
      if (byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_during_write got=%b want=0", byte_ready);
      end
      n_writes++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      tick($urandom_range(0, 2));
    end
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL ready_timeout byte=%h waited=%0d cycles", b, t);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input bit gap, input bit expect_write);
    send_byte(b0, gap);
    send_byte(b1, gap);
    if (expect_write) sb_q.push_back({exp_addr, {b2[2:0], b1, b0}});
    exp_addr = exp_addr + 8'd1;
    exp_csum = exp_csum ^ b0 ^ b1 ^ b2;
    send_byte(b2, gap);
  endtask

  task automatic check_final(input string tag, input logic want_done, input int want_count,
                             input int writes_before, input int want_writes);
    if (done !== want_done || err !== !want_done || busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_status got done=%b err=%b busy=%b rdy=%b want done=%b err=%b busy=0 rdy=0",
               tag, done, err, busy, byte_ready, want_done, !want_done);
    end
    checks++;
    if (word_count !== 9'(want_count)) begin
      errors++;
      $display("FAIL %s_word_count got=%0d want=%0d", tag, word_count, want_count);
    end
    checks++;
    if (n_writes - writes_before != want_writes) begin
      errors++;
      $display("FAIL %s_write_count got=%0d want=%0d", tag, n_writes - writes_before, want_writes);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes got=%0d pending want=0", tag, sb_q.size());
      sb_q.delete();
    end
    checks++;
  endtask

  task automatic begin_load(input string tag);
    pulse_start();
    checks++;
    if (busy !== 1'b1 || byte_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || word_count !== 9'd0) begin
      errors++;
      $display("FAIL %s_after_start got busy=%b rdy=%b done=%b err=%b wc=%0d want 1 1 0 0 0",
               tag, busy, byte_ready, done, err, word_count);
    end
    exp_addr = 8'd0;
    exp_csum = 8'd0;
  endtask

  task automatic do_load(input string tag, input int n, input bit gap);
    int w0;
    w0 = n_writes;
    begin_load(tag);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++)
      send_word(8'($urandom), 8'($urandom), 8'($urandom_range(0, 7)), gap, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(exp_csum, gap);
`endif
    tick(2);
    check_final(tag, 1'b1, n, w0, n);
  endtask

  task automatic test_reset();
    checks++;
    if (byte_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 8'd0 || wr_data !== 19'd0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || word_count !== 9'd0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b wr_en=%b addr=%0d data=%h busy=%b done=%b err=%b wc=%0d want all 0",
               byte_ready, wr_en, wr_addr, wr_data, busy, done, err, word_count);
    end
  endtask

  task automatic test_single_word();
    int w0;
    w0 = n_writes;
    begin_load("single");
    send_byte(8'd1, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h80, 1'b0);
    sb_q.push_back({8'd0, 19'b0101000000000001000});
    send_byte(8'h02, 1'b0);
    checks++;
    if (wr_en !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_write_timing got wr_en=%b rdy=%b want wr_en=1 rdy=0", wr_en, byte_ready);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h08 ^ 8'h80 ^ 8'h02, 1'b0);
`else
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL single_done_with_write got=%b want=1", done);
    end
`endif
    tick(2);
    check_final("single", 1'b1, 1, w0, 1);
  endtask

  task automatic test_back_to_back();
    begin_load("b2b");
    send_byte(8'd2, 1'b0);
    send_word(8'h11, 8'h22, 8'h03, 1'b0, 1'b1);
    checks++;
    if (wr_en !== 1'b1 || byte_ready !== 1'b0 || word_count !== 9'd1) begin
      errors++;
      $display("FAIL b2b_write_cycle got wr_en=%b rdy=%b wc=%0d want 1 0 1", wr_en, byte_ready, word_count);
    end
    tick(1);
    checks++;
    if (wr_en !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_return got wr_en=%b rdy=%b want 0 1", wr_en, byte_ready);
    end
    send_word(8'h44, 8'h55, 8'h06, 1'b0, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(exp_csum, 1'b0);
`endif
    tick(2);
    check_final("b2b", 1'b1, 2, n_writes - 2, 2);
  endtask

  task automatic test_reserved();
    int w0;
    w0 = n_writes;
    begin_load("rsvd");
    send_byte(8'd3, 1'b0);
    send_word(8'hA5, 8'h5A, 8'h07, 1'b0, 1'b1);
    send_word(8'h01, 8'h02, 8'h0F, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || byte_ready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_immediate got err=%b rdy=%b wr_en=%b busy=%b want 1 0 0 0", err, byte_ready, wr_en, busy);
    end
    tick(2);
    check_final("rsvd", 1'b0, 1, w0, 1);
  endtask

  task automatic test_start_ignored();
    int w0;
    w0 = n_writes;
    begin_load("busy_start");
    send_byte(8'd2, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    pulse_start();
    sb_q.push_back({8'd0, {3'd1, 8'h20, 8'h10}});
    exp_addr = 8'd1;
    exp_csum = 8'h10 ^ 8'h20 ^ 8'h01;
    send_byte(8'h01, 1'b0);
    send_word(8'h30, 8'h40, 8'h05, 1'b0, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(exp_csum, 1'b0);
`endif
    tick(2);
    check_final("busy_start", 1'b1, 2, w0, 2);
  endtask

  task automatic test_reset_midload();
    int w0;
    w0 = n_writes;
    begin_load("rst_mid");
    send_byte(8'd4, 1'b0);
    send_word(8'h01, 8'h02, 8'h03, 1'b1, 1'b1);
    send_word(8'h04, 8'h05, 8'h06, 1'b1, 1'b1);
    send_byte(8'h07, 1'b0);
    send_byte(8'h08, 1'b0);
    rst = 1'b1;
    #1;
    test_reset();
    tick(2);
    rst = 1'b0;
    tick(2);
    checks++;
    if (n_writes - w0 != 2 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_writes got=%0d wr_en=%b want 2 0", n_writes - w0, wr_en);
    end
    do_load("after_rst", 1, 1'b0);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    int w0;
    w0 = n_writes;
    begin_load("bad_csum");
    send_byte(8'd2, 1'b0);
    send_word(8'h12, 8'h34, 8'h01, 1'b0, 1'b1);
    send_word(8'h56, 8'h78, 8'h02, 1'b0, 1'b1);
    send_byte(~exp_csum, 1'b0);
    tick(2);
    check_final("bad_csum", 1'b0, 2, w0, 2);
  endtask
`endif

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'd0;
    tick(3);
    test_reset();
    rst = 1'b0;
    tick(2);
    test_single_word();
    do_load("three_rand", 3, 1'b1);
    test_back_to_back();
    test_reserved();
    test_start_ignored();
    test_reset_midload();
    do_load("full_256", 256, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
